// File: rtl/pipeline_int_ctrl.sv
// Pipeline hazard and nested-interrupt entry controller: load-use stall, branch flush,
// drain-then-enter interrupt sequencing with priority nesting, ERET unwinding and halt.
module pipeline_int_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] int_req,
    input  logic [2:0] int_mask,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_req_w,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       branch_taken,
    input  logic       eret_wb,
    input  logic       halt_wb,
    output logic       pipe_en,
    output logic       if_id_stall,
    output logic       if_id_clr,
    output logic       id_ex_clr,
    output logic       pc_sel_int,
    output logic       epc_we,
    output logic [2:0] ints,
    output logic [2:0] int_ack,
    output logic [2:0] in_service
);

    localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {RUN, DRAIN, ENTER, HALTED} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      lat_q, lat_d;
    logic [2:0]      isv_q, isv_d;

    logic [2:0]      pending, cand_oh, top_oh, isv_eret;
    logic            cand_vld, load_use;

    // A candidate must outrank every level in service, i.e. in_service has no bit at or above it.
    always_comb begin
        pending  = int_req & int_mask;
        cand_vld = 1'b0;
        cand_oh  = '0;
        top_oh   = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (pending[i] && ((isv_q >> i) == 3'b000)) begin
                cand_vld   = 1'b1;
                cand_oh    = '0;
                cand_oh[i] = 1'b1;
            end
            if (isv_q[i]) begin
                top_oh    = '0;
                top_oh[i] = 1'b1;
            end
        end
        isv_eret = eret_wb ? (isv_q & ~top_oh) : isv_q;
    end

    assign load_use = ex_mem_read && (ex_req_w != '0) &&
                      ((id_use_rs && (id_rs == ex_req_w)) || (id_use_rt && (id_rt == ex_req_w)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        isv_d   = isv_q;
        case (state_q)
            RUN: begin
                isv_d = isv_eret;
                if (halt_wb) begin
                    state_d = HALTED;
                end else if (cand_vld && !eret_wb) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_LOAD;
                    lat_d   = cand_oh;
                end
            end
            DRAIN: begin
                if (halt_wb) begin
                    state_d = HALTED;
                end else begin
                    isv_d = isv_eret;
                    if (cnt_q == '0) state_d = ENTER;
                    else             cnt_d   = cnt_q - CW'(1);
                end
            end
            ENTER: begin
                if (halt_wb) begin
                    state_d = HALTED;
                end else begin
                    isv_d   = isv_eret | lat_q;
                    state_d = RUN;
                end
            end
            HALTED: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            lat_q   <= '0;
            isv_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            isv_q   <= isv_d;
        end
    end

    // Hazard controls must act in the cycle they are seen, so outputs decode state and inputs directly.
    always_comb begin
        pipe_en     = 1'b1;
        if_id_stall = 1'b0;
        if_id_clr   = 1'b1;
        id_ex_clr   = 1'b1;
        pc_sel_int  = 1'b0;
        epc_we      = 1'b0;
        ints        = '0;
        int_ack     = '0;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    if_id_clr = 1'b0;
                    id_ex_clr = 1'b0;
                end else if (load_use) begin
                    if_id_stall = 1'b1;
                    id_ex_clr   = 1'b0;
                end
            end
            DRAIN: begin
                if_id_stall = 1'b1;
                id_ex_clr   = 1'b0;
                if (branch_taken) if_id_clr = 1'b0;
            end
            ENTER: begin
                if (!halt_wb) begin
                    pc_sel_int = 1'b1;
                    epc_we     = 1'b1;
                    ints       = lat_q;
                    int_ack    = lat_q;
                    if_id_clr  = 1'b0;
                    id_ex_clr  = 1'b0;
                end
            end
            HALTED: pipe_en = 1'b0;
        endcase
    end

    assign in_service = isv_q;

endmodule

// File: tb/tb_pipeline_int_ctrl.sv
// Directed bench for pipeline_int_ctrl: expected output vectors are queued per step
// and popped against the DUT mid-cycle.
module tb_pipeline_int_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] int_req, int_mask;
    logic       ex_mem_read;
    logic [4:0] ex_req_w, id_rs, id_rt;
    logic       id_use_rs, id_use_rt, branch_taken, eret_wb, halt_wb;
    logic       pipe_en, if_id_stall, if_id_clr, id_ex_clr, pc_sel_int, epc_we;
    logic [2:0] ints, int_ack, in_service;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [14:0] exp;
    } sb_t;
    sb_t sb[$];

    pipeline_int_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .int_req(int_req), .int_mask(int_mask),
        .ex_mem_read(ex_mem_read), .ex_req_w(ex_req_w), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .branch_taken(branch_taken),
        .eret_wb(eret_wb), .halt_wb(halt_wb), .pipe_en(pipe_en), .if_id_stall(if_id_stall),
        .if_id_clr(if_id_clr), .id_ex_clr(id_ex_clr), .pc_sel_int(pc_sel_int),
        .epc_we(epc_we), .ints(ints), .int_ack(int_ack), .in_service(in_service)
    );

    always #5 clk = ~clk;

    wire [14:0] obs = {pipe_en, if_id_stall, if_id_clr, id_ex_clr, pc_sel_int, epc_we,
                       ints, int_ack, in_service};

    function automatic logic [14:0] mk(input logic pe, input logic st, input logic ic,
                                       input logic dc, input logic pc, input logic ep,
                                       input logic [2:0] in, input logic [2:0] ak,
                                       input logic [2:0] isv);
        return {pe, st, ic, dc, pc, ep, in, ak, isv};
    endfunction

    function automatic logic [14:0] idle(input logic [2:0] isv);
        return mk(1, 0, 1, 1, 0, 0, 3'b000, 3'b000, isv);
    endfunction
    function automatic logic [14:0] stall(input logic [2:0] isv);
        return mk(1, 1, 1, 0, 0, 0, 3'b000, 3'b000, isv);
    endfunction
    function automatic logic [14:0] drn(input logic br, input logic [2:0] isv);
        return mk(1, 1, !br, 0, 0, 0, 3'b000, 3'b000, isv);
    endfunction
    function automatic logic [14:0] enter(input logic [2:0] oh, input logic [2:0] isv);
        return mk(1, 0, 0, 0, 1, 1, oh, oh, isv);
    endfunction
    function automatic logic [14:0] halted(input logic [2:0] isv);
        return mk(0, 0, 1, 1, 0, 0, 3'b000, 3'b000, isv);
    endfunction

    // Inputs are driven just after a rising edge; the check lands mid-cycle, then time
    // advances to just after the next rising edge.
    task automatic chk(input string tag, input logic [14:0] e);
        sb_t it;
        it.tag = tag;
        it.exp = e;
        sb.push_back(it);
        #2;
        it = sb.pop_front();
        checks++;
        assert (obs === it.exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", it.tag, obs, it.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        int_req = '0; int_mask = 3'b111; ex_mem_read = 0; ex_req_w = '0;
        id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
        branch_taken = 0; eret_wb = 0; halt_wb = 0;
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        #1;
        chk("reset_idle", idle(3'b000));
        rst_n = 1;
        chk("post_reset_idle", idle(3'b000));
        eret_wb = 1;
        chk("eret_empty", idle(3'b000));
        eret_wb = 0;
        chk("eret_empty_after", idle(3'b000));

        ex_mem_read = 1; ex_req_w = 5; id_rs = 5; id_use_rs = 1;
        chk("load_use_rs", stall(3'b000));
        clear_inputs();
        chk("load_use_one_cycle", idle(3'b000));
        ex_mem_read = 1; ex_req_w = 0; id_rs = 0; id_use_rs = 1;
        chk("load_use_r0", idle(3'b000));
        ex_req_w = 7; id_rt = 7; id_use_rt = 1; id_use_rs = 0;
        chk("load_use_rt", stall(3'b000));
        branch_taken = 1;
        chk("branch_over_stall", mk(1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000));

        clear_inputs();
        int_req = 3'b010;
        chk("int_run_cycle", idle(3'b000));
        int_req = 3'b000;
        chk("drain1", drn(0, 3'b000));
        branch_taken = 1;
        chk("drain2_branch", drn(1, 3'b000));
        branch_taken = 0;
        chk("drain3", drn(0, 3'b000));
        chk("enter_l1", enter(3'b010, 3'b000));

        int_req = 3'b101;
        chk("nest_run", idle(3'b010));
        chk("nest_drain1", drn(0, 3'b010));
        chk("nest_drain2", drn(0, 3'b010));
        chk("nest_drain3", drn(0, 3'b010));
        chk("nest_enter_l2", enter(3'b100, 3'b010));
        chk("nest_l0_waits_a", idle(3'b110));
        chk("nest_l0_waits_b", idle(3'b110));
        int_req = 3'b000; eret_wb = 1;
        chk("eret_cycle", idle(3'b110));
        eret_wb = 0; int_req = 3'b100; int_mask = 3'b011;
        chk("eret_cleared_l2", idle(3'b010));
        chk("masked_no_entry", idle(3'b010));

        int_mask = 3'b111; eret_wb = 1;
        chk("eret_with_cand", idle(3'b010));
        eret_wb = 0;
        chk("cand_next_cycle_run", idle(3'b000));
        chk("cand_drain1", drn(0, 3'b000));
        halt_wb = 1;
        chk("halt_in_drain", drn(0, 3'b000));
        halt_wb = 0; int_req = 3'b111; eret_wb = 1; branch_taken = 1;
        ex_mem_read = 1; ex_req_w = 3; id_rs = 3; id_use_rs = 1;
        chk("halted_a", halted(3'b000));
        chk("halted_b", halted(3'b000));

        clear_inputs();
        rst_n = 0;
        chk("reset_from_halt", idle(3'b000));
        rst_n = 1;
        chk("run_after_reset", idle(3'b000));

        int_req = 3'b001;
        chk("int0_run", idle(3'b000));
        int_req = 3'b000;
        chk("int0_drain1", drn(0, 3'b000));
        rst_n = 0;
        chk("reset_mid_drain", idle(3'b000));
        rst_n = 1;
        chk("after_drain_reset_a", idle(3'b000));
        chk("after_drain_reset_b", idle(3'b000));
        chk("after_drain_reset_c", idle(3'b000));
        chk("after_drain_reset_d", idle(3'b000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_int_ctrl.md
PIPELINE_INT_CTRL -- requirements
Module: pipeline_int_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are named clk and rst_n.
REQ-002 Parameter DRAIN_CYCLES, default 3: number of bubble cycles inserted before interrupt entry.
REQ-003 clk, input, 1: rising-edge clock.
REQ-004 rst_n, input, 1: asynchronous active-low reset.
REQ-005 int_req, input, 3: level interrupt requests; bit 2 is highest priority.
REQ-006 int_mask, input, 3: per-source enable from CP0; 1 means enabled.
REQ-007 ex_mem_read, input, 1: the instruction in EX is a load.
REQ-008 ex_req_w, input, 5: destination register of the instruction in EX.
REQ-009 id_rs, id_rt, input, 5 each: source registers of the instruction in ID.
REQ-010 id_use_rs, id_use_rt, input, 1 each: the ID instruction reads rs or rt.
REQ-011 branch_taken, input, 1: EX redirects the PC.
REQ-012 eret_wb, input, 1: an ERET is retiring in WB.
REQ-013 halt_wb, input, 1: a halt is retiring in WB.
REQ-014 pipe_en, output, 1: global enable to all four pipeline registers.
REQ-015 if_id_stall, output, 1: hold the IF/ID register and the PC.
REQ-016 if_id_clr, id_ex_clr, output, 1 each: active-low flush of the IF/ID and ID/EX registers.
REQ-017 pc_sel_int, output, 1: select the interrupt vector as the next PC.
REQ-018 epc_we, output, 1: CP0 captures the return PC.
REQ-019 ints, output, 3: one-hot source being entered; valid while pc_sel_int=1.
REQ-020 int_ack, output, 3: one-hot single-cycle acknowledge to the device.
REQ-021 in_service, output, 3: registered mask of interrupt levels currently being serviced.

Function
REQ-022 The FSM SHALL have the states RUN, DRAIN, ENTER and HALTED.
REQ-023 cur_level SHALL be the index of the highest set bit of in_service, or -1 when in_service is 0.
REQ-024 cand SHALL be the highest-index set bit of int_req & int_mask whose index is greater than cur_level.
REQ-025 RUN: if halt_wb=1, the next state SHALL be HALTED.
REQ-026 RUN: otherwise, if cand exists and eret_wb=0, the block SHALL latch cand, load the counter with DRAIN_CYCLES-1, and go to DRAIN.
REQ-027 RUN load-use: when ex_mem_read=1, ex_req_w!=0, and (id_use_rs and id_rs==ex_req_w, or id_use_rt and id_rt==ex_req_w), the block SHALL drive if_id_stall=1 and id_ex_clr=0 in the same cycle.
REQ-028 RUN branch: when branch_taken=1, the block SHALL drive if_id_clr=0 and id_ex_clr=0; branch flush overrides load-use stall.
REQ-029 DRAIN: the block SHALL drive if_id_stall=1 and id_ex_clr=0 every cycle and decrement the counter, going to ENTER at 0; older instructions in EX/DM/WB complete.
REQ-030 DRAIN: branch_taken still drives if_id_clr=0; a request deasserting during DRAIN does not abort entry.
REQ-031 ENTER, one cycle: the block SHALL drive pc_sel_int=1, epc_we=1, ints=int_ack=onehot(latched), if_id_clr=0 and id_ex_clr=0, set in_service[latched], and return to RUN.
REQ-032 eret_wb=1 in any non-HALTED state SHALL clear the highest set bit of in_service at the next edge; with in_service=0 it has no effect.
REQ-033 halt_wb=1 in DRAIN or ENTER SHALL go to HALTED; no ack issues and in_service is unchanged.
REQ-034 HALTED SHALL drive pipe_en=0, ignore all inputs, and be left only by reset.
REQ-035 Outputs not named for a state SHALL take their idle values: pipe_en=1, stall=0, clr=1, others 0.
REQ-036 pipe_en SHALL be 1 in RUN, DRAIN and ENTER.
REQ-037 If DRAIN_CYCLES=1, the block SHALL go directly from DRAIN to ENTER after 1 cycle.

Reset
REQ-038 rst_n=0 SHALL force, asynchronously, state RUN, in_service=0, counter=0 and latched=0, with all outputs at idle values, including mid-DRAIN.
REQ-039 Release of rst_n SHALL take effect at the first rising clk edge.

Verification
REQ-040 Load-use: ex_mem_read=1, ex_req_w=5, id_rs=5, id_use_rs=1 -> if_id_stall=1 and id_ex_clr=0 for exactly that cycle.
REQ-041 Interrupt entry: int_req=3'b010, int_mask=3'b111, idle -> 3 DRAIN cycles, then ENTER with ints=int_ack=3'b010 and pc_sel_int=1; in_service=3'b010 afterwards.
REQ-042 Nesting: in_service=3'b010, int_req=3'b101 -> level 2 is entered and in_service=3'b110; level 0 waits. eret_wb -> in_service=3'b010.
REQ-043 Masking and ERET: int_req=3'b100, int_mask=3'b011 -> no entry. eret_wb in the same cycle as a new cand -> no DRAIN that cycle, and entry is evaluated on the next cycle.
REQ-044 Halt and reset: halt_wb mid-DRAIN -> HALTED with pipe_en=0 and no int_ack. rst_n pulse -> RUN with in_service=0 and pipe_en=1.
